freq_meter: RTL and testbench

Gate-window frequency counter. It counts rising edges of an asynchronous input over a fixed window of `i_CLK` cycles and reports the count. It is the measuring counterpart of the `i_CLK`-based clock divider: it turns a signal's rate back into a number. The block sits beside the 100 MHz system clock. With `GATE_CYCLES` = 100000000 the window is 1 s and `o_FREQ` reads directly in Hz.

---
 rtl/freq_meter.sv | 149 ++++++++++++++
 tb/tb_freq_meter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Gate-window frequency counter. Counts rising edges of an
//            asynchronous input over GATE_CYCLES cycles of i_CLK and
//            reports the count once per window.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   GATE_CYCLES : window length in i_CLK cycles (>= 2)
//   CNT_W       : width of the edge counter and of o_FREQ
// Ports
//   i_CLK   in   system clock
//   i_RST   in   synchronous active-high reset
//   i_EN    in   measurement enable (level), windows run back-to-back
//   i_SIG   in   asynchronous signal to measure
//   o_FREQ  out  edge count of the last completed window
//   o_VALID out  one-cycle pulse, o_FREQ/o_OVF just updated
//   o_OVF   out  last completed window saturated the counter
//   o_BUSY  out  high while not idle
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 32
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic             i_SIG,
  output logic [CNT_W-1:0] o_FREQ,
  output logic             o_VALID,
  output logic             o_OVF,
  output logic             o_BUSY
);

  localparam int            GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             sig_s1_q, sig_s2_q, sig_s3_q;

  logic             edge_hit;
  logic             cnt_full;
  logic             win_last;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_inc;

  // Two flops resynchronise i_SIG; the third gives the previous sample for
  // rising-edge detection.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sig_s1_q <= 1'b0;
      sig_s2_q <= 1'b0;
      sig_s3_q <= 1'b0;
    end else begin
      sig_s1_q <= i_SIG;
      sig_s2_q <= sig_s1_q;
      sig_s3_q <= sig_s2_q;
    end
  end

  assign edge_hit = sig_s2_q & ~sig_s3_q;
  assign cnt_full = &edge_cnt_q;
  assign win_last = (state_q == ST_GATE) && (gate_cnt_q == GATE_LAST);

  // Count including the current cycle's edge; an edge arriving while the
  // counter is already all-ones is an overflow, the counter holds.
  assign cnt_inc  = (edge_hit && !cnt_full) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
  assign sat_inc  = sat_q | (edge_hit & cnt_full);

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; dropping i_EN in GATE aborts even on the last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_EN) state_d = ST_GATE;
      ST_GATE: begin
        if (!i_EN)        state_d = ST_IDLE;
        else if (win_last) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = i_EN ? ST_GATE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. Counters default to zero, so IDLE, LATCH
  // and an aborted window all leave them cleared; an edge seen in LATCH is
  // therefore dropped.
  always_comb begin
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    sat_d      = 1'b0;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    if ((state_q == ST_GATE) && i_EN) begin
      if (win_last) begin
        freq_d  = cnt_inc;
        ovf_d   = sat_inc;
        valid_d = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt_q + GW'(1);
        edge_cnt_d = cnt_inc;
        sat_d      = sat_inc;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign o_FREQ  = freq_q;
  assign o_VALID = valid_q;
  assign o_OVF   = ovf_q;
  assign o_BUSY  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter. Expected window results are
//            derived from the recorded input samples and the window timing,
//            queued at the window's last GATE edge and compared when the DUT
//            pulses o_VALID. A second instance with CNT_W=3 covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int G  = 100;
  localparam int NS = 4096;

  typedef struct {
    logic [31:0] f;
    logic        o;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, sig, en3, sig3;
  logic [31:0] freq;
  logic        valid, ovf, busy;
  logic [2:0]  freq3;
  logic        valid3, ovf3, busy3;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          samp [NS];
  exp_t        q[$];    // model-derived expectations, main instance
  exp_t        dq[$];   // hand-derived expectations, main instance
  exp_t        dq3[$];  // hand-derived expectations, CNT_W=3 instance
  int          m_phase = 0;
  int          m_start = 0;
  logic        rst_seen = 1'b0;
  logic [31:0] m_last   = '0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_SIG(sig),
    .o_FREQ(freq), .o_VALID(valid), .o_OVF(ovf), .o_BUSY(busy)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) dut3 (
    .i_CLK(clk), .i_RST(rst), .i_EN(en3), .i_SIG(sig3),
    .o_FREQ(freq3), .o_VALID(valid3), .o_OVF(ovf3), .o_BUSY(busy3)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  // Stimulus patterns, indexed by sample number j relative to the enable edge.
  function automatic logic pat(input int mode, input int j);
    case (mode)
      1:       return (j % 10) >= 5;
      2:       return (j == G-2) || (j == G-1) || (j == 2*G) || (j == 2*G+1);
      3:       return ((j % 4) >= 2) && (j <= G+1);
      default: return 1'b0;
    endcase
  endfunction

  // Rising edges seen by the edge detector at edges first..last: the detector
  // at edge m compares the samples taken at edges m-2 and m-3.
  function automatic int count_edges(input int first, input int last);
    int c = 0;
    for (int m = first; m <= last; m++)
      if (samp[m-2] && !samp[m-3]) c++;
    return c;
  endfunction

  // Window-level reference for the main instance.
  always @(posedge clk) begin : model
    automatic int n = cyc + 1;
    automatic int c;
    automatic exp_t e;
    cyc <= n;
    if (n < NS) samp[n] <= rst ? 1'b0 : sig;
    rst_seen <= rst;
    if (rst) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (en) begin m_phase <= 1; m_start <= n; end
        1: begin
          if (!en) m_phase <= 0;
          else if (n - m_start == G) begin
            c = count_edges(m_start + 1, n);
            e.f = 32'(c); e.o = 1'b0; e.cyc = n;
            q.push_back(e);
            m_phase <= 2;
          end
        end
        default: begin
          if (en) begin m_phase <= 1; m_start <= n; end
          else m_phase <= 0;
        end
      endcase
    end
  end

  // Output monitor, sampled half a cycle after each active edge.
  always @(negedge clk) begin : monitor
    logic exp_v;
    logic [31:0] exp_f;
    exp_v = (q.size() > 0) && (q[0].cyc == cyc);
    exp_f = m_last;
    if (rst_seen) exp_f = '0;
    check_eq("valid", {63'd0, valid}, {63'd0, exp_v});
    check_eq("busy", {63'd0, busy}, {63'd0, (m_phase != 0)});
    if (exp_v) begin
      exp_f = q[0].f;
      check_eq("ovf", {63'd0, ovf}, {63'd0, q[0].o});
      void'(q.pop_front());
    end
    check_eq("freq", {32'd0, freq}, {32'd0, exp_f});
    m_last <= exp_f;
    if (rst_seen) begin
      check_eq("rst_valid", {63'd0, valid}, 64'd0);
      check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    end
    if ((dq.size() > 0) && (dq[0].cyc == cyc)) begin
      check_eq("dir_valid", {63'd0, valid}, 64'd1);
      check_eq("dir_freq", {32'd0, freq}, {32'd0, dq[0].f});
      check_eq("dir_ovf", {63'd0, ovf}, {63'd0, dq[0].o});
      void'(dq.pop_front());
    end
    if (valid3) begin
      if (dq3.size() == 0) begin
        check_eq("v3_unexpected", 64'd1, 64'd0);
      end else begin
        check_eq("v3_cyc", 64'(cyc), 64'(dq3[0].cyc));
        check_eq("v3_freq", {61'd0, freq3}, {32'd0, dq3[0].f});
        check_eq("v3_ovf", {63'd0, ovf3}, {63'd0, dq3[0].o});
        void'(dq3.pop_front());
      end
    end
  end

  // Runs ncyc samples of pattern `mode` with i_EN high from the current
  // negedge, then drops i_EN and leaves a short idle gap.
  task automatic run_win(input int mode, input int ncyc);
    en = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      if (j > 0) @(negedge clk);
      sig = pat(mode, j);
    end
    @(negedge clk);
    en  = 1'b0;
    sig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic exp_t mk(input int f, input logic o, input int c);
    exp_t e;
    e.f = 32'(f); e.o = o; e.cyc = c;
    return e;
  endfunction

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    int a;
    rst = 1'b1; en = 1'b1; sig = 1'b0; en3 = 1'b0; sig3 = 1'b0;
    repeat (4) @(negedge clk);

    // Period-10 signal, enabled from reset: two back-to-back windows,
    // i_EN released so that it is seen low in the second LATCH cycle.
    rst = 1'b0;
    a = cyc + 1;
    dq.push_back(mk(10, 1'b0, a + G));
    run_win(1, 2*G + 2);

    // Signal idle for a whole window.
    a = cyc + 1;
    dq.push_back(mk(0, 1'b0, a + G));
    run_win(0, G + 1);

    // Enable seen low at GATE cycle 50: abort, then a full window.
    run_win(1, 50);
    run_win(1, G + 1);

    // Reset at GATE cycle 60.
    en = 1'b1;
    for (int j = 0; j < 60; j++) begin
      if (j > 0) @(negedge clk);
      sig = pat(1, j);
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Edge in the last GATE cycle counts; edge in LATCH is dropped.
    a = cyc + 1;
    dq.push_back(mk(1, 1'b0, a + G));
    dq.push_back(mk(0, 1'b0, a + 2*G + 1));
    dq.push_back(mk(0, 1'b0, a + 3*G + 2));
    run_win(2, 3*G + 3);

    // Narrow counter: period-4 signal saturates, then a quiet window.
    a = cyc + 1;
    dq3.push_back(mk(7, 1'b1, a + G));
    dq3.push_back(mk(0, 1'b0, a + 2*G + 1));
    en3 = 1'b1;
    for (int j = 0; j < 2*G + 2; j++) begin
      if (j > 0) @(negedge clk);
      sig3 = pat(3, j);
    end
    @(negedge clk);
    en3 = 1'b0; sig3 = 1'b0;
    repeat (5) @(negedge clk);

    check_eq("q_left", 64'(q.size()), 64'd0);
    check_eq("dq_left", 64'(dq.size()), 64'd0);
    check_eq("dq3_left", 64'(dq3.size()), 64'd0);
    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    check_eq("idle_busy3", {63'd0, busy3}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
